// File: rtl/sap1_pkg.sv
// sap1_pkg: SAP-1 opcodes, control-word bit indices and named control words.
package sap1_pkg;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam int CP     = 11;
  localparam int EP     = 10;
  localparam int LM_BAR = 9;
  localparam int CE_BAR = 8;
  localparam int LL_BAR = 7;
  localparam int EI_BAR = 6;
  localparam int LA_BAR = 5;
  localparam int EA     = 4;
  localparam int SU     = 3;
  localparam int EU     = 2;
  localparam int LB_BAR = 1;
  localparam int LO_BAR = 0;
  // Each word is the idle word with its asserted signals flipped.
  localparam logic [11:0] CW_IDLE   = 12'h3E3;
  localparam logic [11:0] CW_T1     = CW_IDLE ^ (12'h1 << EP) ^ (12'h1 << LM_BAR);
  localparam logic [11:0] CW_T2     = CW_IDLE ^ (12'h1 << CP);
  localparam logic [11:0] CW_T3     = CW_IDLE ^ (12'h1 << CE_BAR) ^ (12'h1 << LL_BAR);
  localparam logic [11:0] CW_MEM_T4 = CW_IDLE ^ (12'h1 << LM_BAR) ^ (12'h1 << EI_BAR);
  localparam logic [11:0] CW_LDA_T5 = CW_IDLE ^ (12'h1 << CE_BAR) ^ (12'h1 << LA_BAR);
  localparam logic [11:0] CW_ALU_T5 = CW_IDLE ^ (12'h1 << CE_BAR) ^ (12'h1 << LB_BAR);
  localparam logic [11:0] CW_ADD_T6 = CW_IDLE ^ (12'h1 << LA_BAR) ^ (12'h1 << EU);
  localparam logic [11:0] CW_SUB_T6 = CW_ADD_T6 ^ (12'h1 << SU);
  localparam logic [11:0] CW_OUT_T4 = CW_IDLE ^ (12'h1 << EA) ^ (12'h1 << LO_BAR);
  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction
endpackage

// File: rtl/ring_counter6.sv
// ring_counter6: one-hot 6-state ring, async clear to T1, hold, and recovery to T1.
module ring_counter6
  import sap1_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_clr_bar,
  input  logic       i_hold,
  output logic [5:0] o_t
);
  logic [5:0] r_t;
  always_ff @(posedge i_clk or negedge i_clr_bar) begin
    if (!i_clr_bar) r_t <= 6'b000001;
    else if (!is_onehot6(r_t)) r_t <= 6'b000001;
    else if (!i_hold) r_t <= {r_t[4:0], r_t[5]};
  end
  assign o_t = r_t;
endmodule

// File: rtl/cont_seq.sv
// cont_seq: SAP-1 controller-sequencer; ring-counter timing, opcode decode, halt latch.
module cont_seq
  import sap1_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR_BAR,
  input  logic [3:0]  OPCODE,
  output logic [11:0] CONT_SIGNAL,
  output logic [5:0]  T_STATE,
  output logic        HLT
);
  logic        r_hlt;
  logic        w_hlt_t4;
  logic [11:0] w_cw;
  assign w_hlt_t4 = T_STATE[3] && (OPCODE == OP_HLT);
  ring_counter6 u_ring (
    .i_clk    (CLK),
    .i_clr_bar(CLR_BAR),
    .i_hold   (r_hlt | w_hlt_t4),
    .o_t      (T_STATE)
  );
  always_ff @(posedge CLK or negedge CLR_BAR) begin
    if (!CLR_BAR) r_hlt <= 1'b0;
    else if (w_hlt_t4) r_hlt <= 1'b1;
  end
  always_comb begin
    w_cw = CW_IDLE;
    if (T_STATE[0]) w_cw = CW_T1;
    else if (T_STATE[1]) w_cw = CW_T2;
    else if (T_STATE[2]) w_cw = CW_T3;
    else if (T_STATE[3])
      w_cw = (OPCODE == OP_LDA || OPCODE == OP_ADD || OPCODE == OP_SUB) ? CW_MEM_T4 :
             (OPCODE == OP_OUT) ? CW_OUT_T4 : CW_IDLE;
    else if (T_STATE[4])
      w_cw = (OPCODE == OP_LDA) ? CW_LDA_T5 :
             (OPCODE == OP_ADD || OPCODE == OP_SUB) ? CW_ALU_T5 : CW_IDLE;
    else if (T_STATE[5])
      w_cw = (OPCODE == OP_ADD) ? CW_ADD_T6 : (OPCODE == OP_SUB) ? CW_SUB_T6 : CW_IDLE;
  end
  assign CONT_SIGNAL = (!CLR_BAR || r_hlt) ? CW_IDLE : w_cw;
  assign HLT = r_hlt;
endmodule

// File: doc/cont_seq.md
# cont_seq

Controller-sequencer for the SAP-1 microprocessor: a six-state ring counter plus instruction decoder that generates the 12-bit `CONT_SIGNAL` control word consumed by the control-signal bus splitter. It takes the opcode nibble from the instruction register and sequences fetch (T1–T3) and execute (T4–T6) for LDA, ADD, SUB, OUT and HLT. It also drives the halt flag that stops the machine.

## Interface
- No parameters; all widths and encodings are fixed by the SAP-1 architecture.
- `CLK`  in  1  system clock; all state changes on rising edge.
- `CLR_BAR`  in  1  asynchronous, active-low reset.
- `OPCODE`  in  4  upper nibble of the instruction register; valid from T4 onward.
- `CONT_SIGNAL`  out  12  control word `[11]CP [10]EP [9]LM_BAR [8]CE_BAR [7]LL_BAR [6]EI_BAR [5]LA_BAR [4]EA [3]SU [2]EU [1]LB_BAR [0]LO_BAR`.
- `T_STATE`  out  6  one-hot ring state; bit0 = T1 … bit5 = T6.
- `HLT`  out  1  high once a HLT instruction executes.

## Operation
- Idle word, meaning all signals inactive: 0x3E3.
- Ring advances T1→T2→…→T6→T1, one state per clock, except when halted.
- `CONT_SIGNAL` is decoded combinationally from `T_STATE` and `OPCODE`, and forced to 0x3E3 while `CLR_BAR` is low or `HLT` is 1.
- Fetch words, independent of `OPCODE`:
  - T1: 0x5E3 (EP, LM_BAR low).
  - T2: 0xBE3 (CP).
  - T3: 0x263 (CE_BAR, LL_BAR low).
- LDA (0000):
  - T4: 0x1A3 (LM_BAR, EI_BAR low).
  - T5: 0x2C3 (CE_BAR, LA_BAR low).
  - T6: 0x3E3.
- ADD (0001):
  - T4: 0x1A3.
  - T5: 0x2E1 (CE_BAR, LB_BAR low).
  - T6: 0x3C7 (LA_BAR low, EU).
- SUB (0010): same as ADD, except T6 = 0x3CF (adds SU).
- OUT (1110):
  - T4: 0x3F2 (EA, LO_BAR low).
  - T5, T6: 0x3E3.
- HLT (1111):
  - In T4, the rising edge registers `HLT`=1 and holds the ring at T4.
  - The halt state persists until `CLR_BAR` goes low; `CLK` has no further effect.
- Any other opcode executes as a NOP: T4–T6 emit 0x3E3.
- `OPCODE` is ignored during T1–T3.

## Timing
- Reset (`CLR_BAR` low, asynchronous) gives `T_STATE`=000001, `HLT`=0, `CONT_SIGNAL`=0x3E3 immediately, and holds them while low.
- After reset release, `CONT_SIGNAL`=0x5E3 (T1) in the same cycle; the first rising edge moves to T2.
- Latency: a control word is valid for exactly the one clock period of its T-state. A full instruction takes 6 clocks.
- `OPCODE` must be stable from the T3→T4 edge through T6. A change mid-execute alters the decode combinationally; the bench treats this as illegal stimulus.
- Reset asserted mid-instruction aborts it; no partial state survives.
- Wrap-around: the T6 edge always returns to T1. There is no illegal ring state reachable from reset. If a non-one-hot value is ever detected, the next edge forces T1.

## Structure
- Package `sap1_pkg` holds:
  - Opcode constants `OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`.
  - Bit-index constants for every `CONT_SIGNAL` field.
  - The named control-word constants (`CW_IDLE`=0x3E3, `CW_T1`, `CW_T2`, `CW_T3`, …).
  - The shared splitter uses the same bit indices.
- Sub-module `ring_counter6`: one-hot 6-bit ring with async active-low clear to T1, a `hold` input, and one-hot recovery.
- Top level contains the decoder, the halt register and the output gating.

## Test plan
- Reset, release with `OPCODE`=0000 → `CONT_SIGNAL` 0x5E3, 0xBE3, 0x263, 0x1A3, 0x2C3, 0x3E3; `T_STATE` 01,02,04,08,10,20 hex; 7th cycle back to 0x5E3.
- `OPCODE`=0001 → T4–T6 give 0x1A3, 0x2E1, 0x3C7; with `OPCODE`=0010 → 0x1A3, 0x2E1, 0x3CF.
- `OPCODE`=1110 → T4–T6 give 0x3F2, 0x3E3, 0x3E3; fetch words unchanged.
- `OPCODE`=1111 → after the T4 edge, `HLT`=1, `T_STATE`=001000 and `CONT_SIGNAL`=0x3E3 for 20 further clocks; a `CLR_BAR` pulse returns to T1 with `HLT`=0.
- `CLR_BAR` dropped asynchronously mid-T5 of an ADD → same instant `T_STATE`=000001 and `CONT_SIGNAL`=0x3E3; after release, 0x5E3.
- `OPCODE`=0101 (undefined), toggled randomly during T1–T3 → fetch words exact; T4–T6 all 0x3E3; `HLT` stays 0.
